// File: rtl/eth_phy_rx_lock_mon.sv
// ---------------------------------------------------------------------------
// eth_phy_rx_lock_mon
//
// Multi-lane 64b/66b receive block-lock and BER monitor. It sits between the
// SERDES gearbox and the PCS decoder.
//
// Each lane checks its sync headers and drives bitslip until the lane
// achieves block lock. While locked, a lane drops lock after too many bad
// headers within an evaluation window. Each lane also tracks BER over a
// shared 125 us window and keeps a saturating error counter. After repeated
// slips without lock, the lane pulses a SERDES reset request.
//
// Ports
//   rx_clk               receive clock
//   rx_rst_n             asynchronous active-low reset
//   serdes_rx_hdr        sync headers, lane k at [k*HDR_WIDTH +: HDR_WIDTH]
//   serdes_rx_hdr_valid  per-lane header qualifier (0 = gearbox stall)
//   cfg_err_clr          synchronous clear of all error counters
//   serdes_rx_bitslip    per-lane bitslip request
//   serdes_rx_reset_req  per-lane one-cycle SERDES reset request
//   rx_block_lock        per-lane block lock
//   rx_high_ber          per-lane high BER flag
//   rx_status            registered rx_block_lock & ~rx_high_ber
//   rx_error_count       per-lane saturating invalid-header count
//   rx_all_lock          registered AND of all rx_block_lock bits
// ---------------------------------------------------------------------------
module eth_phy_rx_lock_mon #(
  parameter int LANES               = 4,
  parameter int HDR_WIDTH           = 2,
  parameter int LOCK_COUNT          = 64,
  parameter int WINDOW              = 1024,
  parameter int UNLOCK_THRESH       = 16,
  parameter int BITSLIP_HIGH_CYCLES = 1,
  parameter int BITSLIP_LOW_CYCLES  = 8,
  parameter int SLIP_LIMIT          = 128,
  parameter int COUNT_125US         = 19531,
  parameter int BER_THRESH          = 16,
  parameter int ERR_CNT_WIDTH       = 7
) (
  input  logic                           rx_clk,
  input  logic                           rx_rst_n,
  input  logic [LANES*HDR_WIDTH-1:0]     serdes_rx_hdr,
  input  logic [LANES-1:0]               serdes_rx_hdr_valid,
  input  logic                           cfg_err_clr,
  output logic [LANES-1:0]               serdes_rx_bitslip,
  output logic [LANES-1:0]               serdes_rx_reset_req,
  output logic [LANES-1:0]               rx_block_lock,
  output logic [LANES-1:0]               rx_high_ber,
  output logic [LANES-1:0]               rx_status,
  output logic [LANES*ERR_CNT_WIDTH-1:0] rx_error_count,
  output logic                           rx_all_lock
);

  localparam int SLIP_CYCLES = BITSLIP_HIGH_CYCLES + BITSLIP_LOW_CYCLES;
  localparam int LCW = $clog2(LOCK_COUNT + 1);
  localparam int WCW = $clog2(WINDOW + 1);
  localparam int ICW = $clog2(UNLOCK_THRESH + 1);
  localparam int SCW = $clog2(SLIP_LIMIT + 1);
  localparam int STW = $clog2(SLIP_CYCLES + 1);
  localparam int TW  = $clog2(COUNT_125US + 1);
  localparam int BCW = $clog2(BER_THRESH + 1);

  typedef enum logic [1:0] {
    ST_UNLOCKED = 2'd0,
    ST_SLIP     = 2'd1,
    ST_LOCKED   = 2'd2
  } state_t;

  // Shared free-running BER window timer.
  logic [TW-1:0] ber_timer_reg;
  logic          ber_wrap;

  assign ber_wrap = (ber_timer_reg == TW'(COUNT_125US - 1));

  always_ff @(posedge rx_clk or negedge rx_rst_n) begin
    if (!rx_rst_n) begin
      ber_timer_reg <= '0;
    end else if (ber_wrap) begin
      ber_timer_reg <= '0;
    end else begin
      ber_timer_reg <= ber_timer_reg + 1'b1;
    end
  end

  logic [LANES-1:0] block_lock_vec;
  logic [LANES-1:0] high_ber_vec;

  for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
    logic [HDR_WIDTH-1:0] hdr;
    logic                 hdr_ok;
    logic                 good;
    logic                 bad;

    state_t               state_reg;
    state_t               state_next;
    logic [LCW-1:0]       lock_cnt_reg;
    logic [SCW-1:0]       slip_cnt_reg;
    logic [STW-1:0]       slip_tmr_reg;
    logic [WCW-1:0]       win_cnt_reg;
    logic [ICW-1:0]       inv_cnt_reg;
    logic                 reset_req_reg;
    logic [BCW-1:0]       ber_cnt_reg;
    logic                 high_ber_reg;
    logic [ERR_CNT_WIDTH-1:0] err_cnt_reg;

    logic                 lock_done;
    logic                 unlock_hit;
    logic                 slip_done;
    logic                 slip_over;
    logic                 lock_out;
    logic                 slip_out;

    assign hdr    = serdes_rx_hdr[gi*HDR_WIDTH +: HDR_WIDTH];
    assign hdr_ok = (hdr == HDR_WIDTH'(1)) || (hdr == HDR_WIDTH'(2));
    assign good   = serdes_rx_hdr_valid[gi] && hdr_ok;
    assign bad    = serdes_rx_hdr_valid[gi] && !hdr_ok;

    assign lock_done  = good && (lock_cnt_reg == LCW'(LOCK_COUNT - 1));
    assign unlock_hit = bad && (inv_cnt_reg == ICW'(UNLOCK_THRESH - 1));
    assign slip_done  = (slip_tmr_reg == STW'(SLIP_CYCLES - 1));
    assign slip_over  = (slip_cnt_reg == SCW'(SLIP_LIMIT - 1));

    // State register.
    always_ff @(posedge rx_clk or negedge rx_rst_n) begin
      if (!rx_rst_n) begin
        state_reg <= ST_UNLOCKED;
      end else begin
        state_reg <= state_next;
      end
    end

    // Next-state logic. In UNLOCKED, a bad header takes priority over lock.
    always_comb begin
      state_next = state_reg;
      case (state_reg)
        ST_UNLOCKED: begin
          if (bad) begin
            state_next = ST_SLIP;
          end else if (lock_done) begin
            state_next = ST_LOCKED;
          end
        end
        ST_SLIP: begin
          if (slip_done) begin
            state_next = ST_UNLOCKED;
          end
        end
        ST_LOCKED: begin
          if (unlock_hit) begin
            state_next = ST_UNLOCKED;
          end
        end
        default: state_next = ST_UNLOCKED;
      endcase
    end

    // Output decode from the registered state, so outputs are glitch-free
    // and fall to 0 with the asynchronous reset.
    always_comb begin
      lock_out = 1'b0;
      slip_out = 1'b0;
      case (state_reg)
        ST_LOCKED: lock_out = 1'b1;
        ST_SLIP:   slip_out = (slip_tmr_reg < STW'(BITSLIP_HIGH_CYCLES));
        default:   ;
      endcase
    end

    // Lock, slip and window counters.
    always_ff @(posedge rx_clk or negedge rx_rst_n) begin
      if (!rx_rst_n) begin
        lock_cnt_reg  <= '0;
        slip_cnt_reg  <= '0;
        slip_tmr_reg  <= '0;
        win_cnt_reg   <= '0;
        inv_cnt_reg   <= '0;
        reset_req_reg <= 1'b0;
      end else begin
        reset_req_reg <= 1'b0;
        case (state_reg)
          ST_UNLOCKED: begin
            if (bad) begin
              lock_cnt_reg <= '0;
              slip_tmr_reg <= '0;
              // The slip that reaches the limit also fires the reset request.
              // The slip itself still proceeds.
              if (slip_over) begin
                slip_cnt_reg  <= '0;
                reset_req_reg <= 1'b1;
              end else begin
                slip_cnt_reg <= slip_cnt_reg + 1'b1;
              end
            end else if (lock_done) begin
              lock_cnt_reg <= '0;
              slip_cnt_reg <= '0;
              win_cnt_reg  <= '0;
              inv_cnt_reg  <= '0;
            end else if (good) begin
              lock_cnt_reg <= lock_cnt_reg + 1'b1;
            end
          end
          ST_SLIP: begin
            slip_tmr_reg <= slip_tmr_reg + 1'b1;
          end
          ST_LOCKED: begin
            if (serdes_rx_hdr_valid[gi]) begin
              if (unlock_hit || (win_cnt_reg == WCW'(WINDOW - 1))) begin
                win_cnt_reg <= '0;
                inv_cnt_reg <= '0;
              end else begin
                win_cnt_reg <= win_cnt_reg + 1'b1;
                if (bad) begin
                  inv_cnt_reg <= inv_cnt_reg + 1'b1;
                end
              end
            end
          end
          default: ;
        endcase
      end
    end

    // BER count and error counter. A hit in the wrap cycle seeds the next
    // window rather than the one being evaluated.
    always_ff @(posedge rx_clk or negedge rx_rst_n) begin
      if (!rx_rst_n) begin
        ber_cnt_reg  <= '0;
        high_ber_reg <= 1'b0;
        err_cnt_reg  <= '0;
      end else begin
        if (ber_wrap) begin
          high_ber_reg <= (ber_cnt_reg >= BCW'(BER_THRESH));
          ber_cnt_reg  <= bad ? BCW'(1) : '0;
        end else if (bad && (ber_cnt_reg != BCW'(BER_THRESH))) begin
          ber_cnt_reg <= ber_cnt_reg + 1'b1;
        end

        if (cfg_err_clr) begin
          err_cnt_reg <= '0;
        end else if (bad && (state_reg != ST_SLIP) && (err_cnt_reg != '1)) begin
          err_cnt_reg <= err_cnt_reg + 1'b1;
        end
      end
    end

    assign block_lock_vec[gi]      = lock_out;
    assign high_ber_vec[gi]        = high_ber_reg;
    assign serdes_rx_bitslip[gi]   = slip_out;
    assign serdes_rx_reset_req[gi] = reset_req_reg;
    assign rx_error_count[gi*ERR_CNT_WIDTH +: ERR_CNT_WIDTH] = err_cnt_reg;
  end

  logic [LANES-1:0] status_reg;
  logic             all_lock_reg;

  always_ff @(posedge rx_clk or negedge rx_rst_n) begin
    if (!rx_rst_n) begin
      status_reg   <= '0;
      all_lock_reg <= 1'b0;
    end else begin
      status_reg   <= block_lock_vec & ~high_ber_vec;
      all_lock_reg <= &block_lock_vec;
    end
  end

  assign rx_block_lock = block_lock_vec;
  assign rx_high_ber   = high_ber_vec;
  assign rx_status     = status_reg;
  assign rx_all_lock   = all_lock_reg;

endmodule

// File: tb/tb_eth_phy_rx_lock_mon.sv
// ---------------------------------------------------------------------------
// tb_eth_phy_rx_lock_mon
//
// Directed self-checking bench for eth_phy_rx_lock_mon.
// The DUT uses a 100-cycle BER window and a slip limit of 4; all other
// parameters take their default values.
// Table segments drive a fixed header pattern for N cycles and then compare
// the outputs. Hand-written sequences cover slip timing, window unlock, BER
// windows, slip-limit resets, counter clear and asynchronous reset.
// ---------------------------------------------------------------------------
module tb_eth_phy_rx_lock_mon;

  logic        rx_clk = 1'b0;
  logic        rx_rst_n;
  logic [7:0]  serdes_rx_hdr;
  logic [3:0]  serdes_rx_hdr_valid;
  logic        cfg_err_clr;
  logic [3:0]  serdes_rx_bitslip;
  logic [3:0]  serdes_rx_reset_req;
  logic [3:0]  rx_block_lock;
  logic [3:0]  rx_high_ber;
  logic [3:0]  rx_status;
  logic [27:0] rx_error_count;
  logic        rx_all_lock;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  always #5 rx_clk = ~rx_clk;

  eth_phy_rx_lock_mon #(
    .COUNT_125US (100),
    .SLIP_LIMIT  (4)
  ) dut (
    .rx_clk              (rx_clk),
    .rx_rst_n            (rx_rst_n),
    .serdes_rx_hdr       (serdes_rx_hdr),
    .serdes_rx_hdr_valid (serdes_rx_hdr_valid),
    .cfg_err_clr         (cfg_err_clr),
    .serdes_rx_bitslip   (serdes_rx_bitslip),
    .serdes_rx_reset_req (serdes_rx_reset_req),
    .rx_block_lock       (rx_block_lock),
    .rx_high_ber         (rx_high_ber),
    .rx_status           (rx_status),
    .rx_error_count      (rx_error_count),
    .rx_all_lock         (rx_all_lock)
  );

  typedef struct {
    string      name;
    logic [7:0] hdr;
    logic [3:0] vld;
    int         n;
    logic [3:0] lock;
    logic [3:0] slip;
    logic [3:0] ber;
    logic [3:0] status;
    logic       all;
  } vec_t;

  vec_t tbl [7];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end else begin
      $display("ok   %s: 0x%0h", name, act);
    end
  endtask

  task automatic apply(input logic [7:0] h, input logic [3:0] v, input logic c);
    serdes_rx_hdr       = h;
    serdes_rx_hdr_valid = v;
    cfg_err_clr         = c;
    @(posedge rx_clk);
    #1;
    cyc++;
  endtask

  function automatic logic [6:0] errc(input int lane);
    logic [27:0] v;
    v = rx_error_count;
    return v[lane*7 +: 7];
  endfunction

  task automatic run_tbl(input int first, input int last);
    for (int k = first; k <= last; k++) begin
      for (int c = 0; c < tbl[k].n; c++) apply(tbl[k].hdr, tbl[k].vld, 1'b0);
      chk({tbl[k].name, ".lock"},   32'(rx_block_lock),     32'(tbl[k].lock));
      chk({tbl[k].name, ".slip"},   32'(serdes_rx_bitslip), 32'(tbl[k].slip));
      chk({tbl[k].name, ".ber"},    32'(rx_high_ber),       32'(tbl[k].ber));
      chk({tbl[k].name, ".status"}, 32'(rx_status),         32'(tbl[k].status));
      chk({tbl[k].name, ".all"},    32'(rx_all_lock),       32'(tbl[k].all));
    end
  endtask

  initial begin
    int bs_cnt;
    int rr_cnt;
    int rr_mis;
    bit found;

    //           name      hdr    vld    n   lock   slip   ber    status all
    tbl[0] = '{"lk63",   8'h01, 4'h1, 63, 4'h0, 4'h0, 4'h0, 4'h0, 1'b0};
    tbl[1] = '{"lk64",   8'h01, 4'h1,  1, 4'h1, 4'h0, 4'h0, 4'h0, 1'b0};
    tbl[2] = '{"st0",    8'h00, 4'h0,  1, 4'h1, 4'h0, 4'h0, 4'h1, 1'b0};
    tbl[3] = '{"all63",  8'h55, 4'hF, 63, 4'h2, 4'h0, 4'h0, 4'h2, 1'b0};
    tbl[4] = '{"all64",  8'h55, 4'hF,  1, 4'hF, 4'h0, 4'h0, 4'h2, 1'b0};
    tbl[5] = '{"allst",  8'h00, 4'h0,  1, 4'hF, 4'h0, 4'h0, 4'hF, 1'b1};
    tbl[6] = '{"hold50", 8'h00, 4'h0, 50, 4'hF, 4'h0, 4'h0, 4'hF, 1'b1};

    rx_rst_n            = 1'b0;
    serdes_rx_hdr       = '0;
    serdes_rx_hdr_valid = '0;
    cfg_err_clr         = 1'b0;
    repeat (3) @(posedge rx_clk);
    #1;
    chk("rst.lock",   32'(rx_block_lock),       32'h0);
    chk("rst.slip",   32'(serdes_rx_bitslip),   32'h0);
    chk("rst.rreq",   32'(serdes_rx_reset_req), 32'h0);
    chk("rst.ber",    32'(rx_high_ber),         32'h0);
    chk("rst.status", 32'(rx_status),           32'h0);
    chk("rst.err",    32'(rx_error_count),      32'h0);
    chk("rst.all",    32'(rx_all_lock),         32'h0);
    rx_rst_n = 1'b1;
    cyc = 0;

    // Lane 0 acquires lock after 64 good headers.
    run_tbl(0, 2);

    // Lane 1 takes one bad header, then 9 ignored cycles of slip.
    apply(8'h0C, 4'h2, 1'b0);
    chk("slip.hi", 32'(serdes_rx_bitslip), 32'h2);
    for (int i = 1; i <= 9; i++) begin
      apply(8'h0C, 4'h2, 1'b0);
      chk($sformatf("slip.lo%0d", i), 32'(serdes_rx_bitslip), 32'h0);
    end
    for (int i = 0; i < 63; i++) apply(8'h08, 4'h2, 1'b0);
    chk("slip.relock63", 32'(rx_block_lock), 32'h1);
    apply(8'h08, 4'h2, 1'b0);
    chk("slip.relock64", 32'(rx_block_lock), 32'h3);
    chk("slip.err1", 32'(errc(1)), 32'd1);

    // Lane 0 receives 15 bad headers per 1024-header window; lock holds.
    for (int w = 0; w < 3; w++) begin
      for (int i = 0; i < 1024; i++) begin
        apply(((i % 64 == 0) && (i < 960)) ? 8'h03 : 8'h01, 4'h1, 1'b0);
      end
      chk($sformatf("win%0d.hold", w), 32'(rx_block_lock), 32'h3);
    end
    // The 16th bad header in one window drops lock, with no slip.
    for (int i = 0; i < 960; i++) apply((i % 64 == 0) ? 8'h03 : 8'h01, 4'h1, 1'b0);
    chk("win3.15bad", 32'(rx_block_lock), 32'h3);
    apply(8'h03, 4'h1, 1'b0);
    chk("win3.drop", 32'(rx_block_lock), 32'h2);
    chk("win3.noslip", 32'(serdes_rx_bitslip), 32'h0);
    chk("win3.err0", 32'(errc(0)), 32'd61);

    // BER on lane 1: 16 bad headers at the start of one aligned window.
    while (cyc % 100 != 0) apply(8'h00, 4'h0, 1'b0);
    for (int t = 0; t < 99; t++) apply((t < 16) ? 8'h0C : 8'h08, 4'h2, 1'b0);
    chk("ber.prewrap", 32'(rx_high_ber), 32'h0);
    chk("ber.relock", 32'(rx_block_lock), 32'h2);
    apply(8'h08, 4'h2, 1'b0);
    chk("ber.wrap", 32'(rx_high_ber), 32'h2);
    chk("ber.status_lag", 32'(rx_status), 32'h2);
    apply(8'h08, 4'h2, 1'b0);
    chk("ber.status", 32'(rx_status), 32'h0);
    for (int t = 1; t < 99; t++) apply(8'h08, 4'h2, 1'b0);
    chk("ber.hold", 32'(rx_high_ber), 32'h2);
    apply(8'h08, 4'h2, 1'b0);
    chk("ber.clean", 32'(rx_high_ber), 32'h0);
    chk("ber.err1", 32'(errc(1)), 32'd17);

    // All lanes lock, then a 50-cycle stall holds state.
    run_tbl(3, 6);
    chk("hold.err0", 32'(errc(0)), 32'd61);

    // Lane 3 sees only 00 headers: slips, reset requests, saturation.
    bs_cnt = 0;
    rr_cnt = 0;
    rr_mis = 0;
    for (int t = 0; t < 1200; t++) begin
      apply(8'h00, 4'h8, 1'b0);
      if (serdes_rx_bitslip[3]) bs_cnt++;
      if (serdes_rx_reset_req[3]) rr_cnt++;
      if ((serdes_rx_reset_req[3] && !serdes_rx_bitslip[3]) || (serdes_rx_reset_req[2:0] != 3'b000))
        rr_mis++;
    end
    chk("lim.slips", 32'(bs_cnt), 32'd119);
    chk("lim.rreq", 32'(rr_cnt), 32'd29);
    chk("lim.rreq_align", 32'(rr_mis), 32'd0);
    chk("lim.err3_sat", 32'(errc(3)), 32'd127);

    // A clear coincides with a bad header on lane 0; the clear wins.
    apply(8'h03, 4'h1, 1'b1);
    chk("clr.err0", 32'(errc(0)), 32'd0);
    chk("clr.err1", 32'(errc(1)), 32'd0);
    chk("clr.err3", 32'(errc(3)), 32'd0);
    apply(8'h03, 4'h1, 1'b0);
    chk("clr.count", 32'(errc(0)), 32'd1);

    // Asynchronous reset while lane 3 is asserting bitslip.
    found = 1'b0;
    for (int t = 0; t < 20 && !found; t++) begin
      apply(8'h00, 4'h8, 1'b0);
      if (serdes_rx_bitslip[3]) found = 1'b1;
    end
    chk("arst.found_slip", 32'(found), 32'd1);
    #2;
    rx_rst_n = 1'b0;
    #1;
    chk("arst.slip",   32'(serdes_rx_bitslip), 32'h0);
    chk("arst.lock",   32'(rx_block_lock),     32'h0);
    chk("arst.status", 32'(rx_status),         32'h0);
    chk("arst.all",    32'(rx_all_lock),       32'h0);
    chk("arst.err",    32'(rx_error_count),    32'h0);
    #20;
    rx_rst_n = 1'b1;
    apply(8'h00, 4'h0, 1'b0);
    apply(8'h00, 4'h0, 1'b0);
    chk("arst.post_lock", 32'(rx_block_lock), 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
